i2c_target_regfile: RTL and testbench

Parametrised I2C target (slave) with an internal register file, replacing the fixed-address, SCL-clocked slave. All bus activity is oversampled on the system clock: filtered START/STOP detection, ACK/NACK generation, open-drain SDA drive, register-pointer auto-increment and repeated START are supported. A local read port exposes register contents, and a write strobe reports every bus write to surrounding logic.

---
 rtl/i2c_target_regfile.sv | 210 +++++++++++++++++++++
 tb/tb_i2c_target_regfile.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_target_regfile.sv
// I2C target with an internal register file; SCL/SDA are oversampled on clk, synchronised and
// glitch-filtered, and all protocol decisions are taken on filtered SCL edges.
module i2c_target_regfile #(
    parameter logic [6:0] DEV_ADDR = 7'h69,
    parameter int         DEPTH    = 39,
    parameter int         FILT     = 3,
    localparam int        PW       = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          scl_i,
    input  logic          sda_i,
    output logic          sda_oe,
    input  logic [PW-1:0] rd_addr,
    output logic [7:0]    rd_data,
    output logic          wr_stb,
    output logic [PW-1:0] wr_addr,
    output logic [7:0]    wr_data,
    output logic          busy
);
    localparam int CW = $clog2(FILT + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_DEVADDR, S_REGADDR, S_WDATA, S_RDATA, S_IGNORE
    } state_t;

    // Index 1 carries SCL, index 0 carries SDA; idle bus is high so flops reset to 1.
    logic [1:0]    r_sync1, r_sync2, r_filt, r_filt_d;
    logic [CW-1:0] r_fcnt [2];

    state_t        r_state, w_state_nxt;
    logic [3:0]    r_bit, w_bit_nxt;
    logic [7:0]    r_shift, w_shift_nxt, r_rbyte, w_rbyte_nxt;
    logic          r_rw, w_rw_nxt, r_mack, w_mack_nxt;
    logic          r_oe, w_oe_nxt, r_busy, w_busy_nxt;
    logic [PW-1:0] r_ptr, w_ptr_nxt, w_ptr_inc;
    logic          w_do_write;
    logic [7:0]    r_mem [DEPTH];

    logic          w_scl_rise, w_scl_fall, w_start, w_stop, w_active;
    logic [7:0]    w_byte_in, w_mem_ptr, w_mem_inc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1  <= 2'b11;
            r_sync2  <= 2'b11;
            r_filt   <= 2'b11;
            r_filt_d <= 2'b11;
            for (int i = 0; i < 2; i++) r_fcnt[i] <= '0;
        end else begin
            r_sync1  <= {scl_i, sda_i};
            r_sync2  <= r_sync1;
            r_filt_d <= r_filt;
            for (int i = 0; i < 2; i++) begin
                if (r_sync2[i] == r_filt[i]) begin
                    r_fcnt[i] <= '0;
                end else if (r_fcnt[i] == CW'(FILT - 1)) begin
                    r_filt[i] <= r_sync2[i];
                    r_fcnt[i] <= '0;
                end else begin
                    r_fcnt[i] <= r_fcnt[i] + 1'b1;
                end
            end
        end
    end

    assign w_scl_rise = r_filt[1] & ~r_filt_d[1];
    assign w_scl_fall = ~r_filt[1] & r_filt_d[1];
    assign w_start    = r_filt_d[0] & ~r_filt[0] & r_filt[1] & r_filt_d[1];
    assign w_stop     = ~r_filt_d[0] & r_filt[0] & r_filt[1] & r_filt_d[1];
    assign w_active   = (r_state == S_DEVADDR) || (r_state == S_REGADDR) ||
                        (r_state == S_WDATA) || (r_state == S_RDATA);
    assign w_byte_in  = {r_shift[6:0], r_filt[0]};
    assign w_ptr_inc  = (r_ptr == PW'(DEPTH - 1)) ? '0 : r_ptr + 1'b1;
    assign w_mem_ptr  = r_mem[r_ptr];
    assign w_mem_inc  = r_mem[w_ptr_inc];

    // r_bit counts sampled bits: 8 means the byte is complete, 9 means the ACK bit was clocked.
    always_comb begin
        w_state_nxt = r_state;
        w_bit_nxt   = r_bit;
        w_shift_nxt = r_shift;
        w_rbyte_nxt = r_rbyte;
        w_rw_nxt    = r_rw;
        w_mack_nxt  = r_mack;
        w_oe_nxt    = r_oe;
        w_busy_nxt  = r_busy;
        w_ptr_nxt   = r_ptr;
        w_do_write  = 1'b0;
        if (w_start) begin
            w_state_nxt = S_DEVADDR;
            w_bit_nxt   = '0;
            w_oe_nxt    = 1'b0;
            w_busy_nxt  = 1'b1;
        end else if (w_stop) begin
            w_state_nxt = S_IDLE;
            w_bit_nxt   = '0;
            w_oe_nxt    = 1'b0;
            w_busy_nxt  = 1'b0;
        end else if (w_active && w_scl_rise) begin
            if (r_bit < 4'd8) begin
                w_shift_nxt = w_byte_in;
                w_bit_nxt   = r_bit + 1'b1;
                if (r_state == S_WDATA && r_bit == 4'd7) begin
                    w_do_write = 1'b1;
                    w_ptr_nxt  = w_ptr_inc;
                end
            end else if (r_bit == 4'd8) begin
                w_mack_nxt = r_filt[0];
                w_bit_nxt  = 4'd9;
            end
        end else if (w_active && w_scl_fall) begin
            if (r_bit == 4'd8) begin
                case (r_state)
                    S_DEVADDR: begin
                        if (r_shift[7:1] == DEV_ADDR) begin
                            w_oe_nxt = 1'b1;
                            w_rw_nxt = r_shift[0];
                        end else begin
                            w_state_nxt = S_IGNORE;
                        end
                    end
                    S_REGADDR: begin
                        if (32'(r_shift) < DEPTH) begin
                            w_ptr_nxt = PW'(r_shift);
                            w_oe_nxt  = 1'b1;
                        end else begin
                            w_state_nxt = S_IGNORE;
                        end
                    end
                    S_WDATA: w_oe_nxt = 1'b1;
                    default: w_oe_nxt = 1'b0;
                endcase
            end else if (r_bit == 4'd9) begin
                w_bit_nxt = '0;
                w_oe_nxt  = 1'b0;
                case (r_state)
                    S_DEVADDR: begin
                        if (r_rw) begin
                            w_state_nxt = S_RDATA;
                            w_rbyte_nxt = w_mem_ptr;
                            w_oe_nxt    = ~w_mem_ptr[7];
                        end else begin
                            w_state_nxt = S_REGADDR;
                        end
                    end
                    S_REGADDR: w_state_nxt = S_WDATA;
                    S_RDATA: begin
                        if (!r_mack) begin
                            w_ptr_nxt   = w_ptr_inc;
                            w_rbyte_nxt = w_mem_inc;
                            w_oe_nxt    = ~w_mem_inc[7];
                        end else begin
                            w_state_nxt = S_IGNORE;
                        end
                    end
                    default: ;
                endcase
            end else if (r_state == S_RDATA && r_bit != 4'd0) begin
                w_oe_nxt = ~r_rbyte[3'(4'd7 - r_bit)];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_bit   <= '0;
            r_shift <= '0;
            r_rbyte <= '0;
            r_rw    <= 1'b0;
            r_mack  <= 1'b1;
            r_oe    <= 1'b0;
            r_busy  <= 1'b0;
            r_ptr   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_bit   <= w_bit_nxt;
            r_shift <= w_shift_nxt;
            r_rbyte <= w_rbyte_nxt;
            r_rw    <= w_rw_nxt;
            r_mack  <= w_mack_nxt;
            r_oe    <= w_oe_nxt;
            r_busy  <= w_busy_nxt;
            r_ptr   <= w_ptr_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= (i == 37) ? 8'd16 : 8'd0;
            rd_data <= '0;
            wr_stb  <= 1'b0;
            wr_addr <= '0;
            wr_data <= '0;
        end else begin
            wr_stb <= w_do_write;
            if (w_do_write) begin
                r_mem[r_ptr] <= w_byte_in;
                wr_addr      <= r_ptr;
                wr_data      <= w_byte_in;
            end
            rd_data <= (32'(rd_addr) < DEPTH) ? r_mem[rd_addr] : 8'd0;
        end
    end

    assign sda_oe = r_oe;
    assign busy   = r_busy;

endmodule

// File: tb/tb_i2c_target_regfile.sv
// Bench for i2c_target_regfile: a bit-banged I2C master drives the bus and every result is
// compared with a register-array model of the target (contents plus register pointer).
module tb_i2c_target_regfile;
    localparam logic [6:0] DEV   = 7'h69;
    localparam int         DEPTH = 39;
    localparam int         FILT  = 3;
    localparam int         PW    = $clog2(DEPTH);
    localparam int         Q     = 8;

    logic          clk   = 1'b0;
    logic          rst_n = 1'b0;
    logic          scl_m = 1'b1;
    logic          sda_m = 1'b1;
    logic [PW-1:0] rd_addr = '0;
    logic          sda_oe, wr_stb, busy;
    logic [PW-1:0] wr_addr;
    logic [7:0]    rd_data, wr_data;
    wire           sda_line = sda_m & ~sda_oe;

    always #5 clk = ~clk;

    i2c_target_regfile #(.DEV_ADDR(DEV), .DEPTH(DEPTH), .FILT(FILT)) dut (
        .clk(clk), .rst_n(rst_n), .scl_i(scl_m), .sda_i(sda_line), .sda_oe(sda_oe),
        .rd_addr(rd_addr), .rd_data(rd_data), .wr_stb(wr_stb), .wr_addr(wr_addr),
        .wr_data(wr_data), .busy(busy)
    );

    int          n_checks = 0;
    int          n_errors = 0;
    logic [7:0]  mmem [DEPTH];
    int          mptr;
    logic [7:0]  wdat [$];
    logic [15:0] wr_q [$];
    int          oe_cnt = 0;

    // Every bus write the target reports, and how long it has pulled SDA low.
    always @(negedge clk) begin
        if (wr_stb === 1'b1) wr_q.push_back({8'(wr_addr), wr_data});
        if (sda_oe === 1'b1) oe_cnt++;
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) mmem[i] = (i == 37) ? 8'd16 : 8'd0;
        mptr = 0;
    endtask

    task automatic q();
        repeat (Q) @(negedge clk);
    endtask

    task automatic m_start();
        sda_m = 1'b1; q(); scl_m = 1'b1; q(); sda_m = 1'b0; q(); scl_m = 1'b0; q();
    endtask

    task automatic m_stop();
        sda_m = 1'b0; q(); scl_m = 1'b1; q(); sda_m = 1'b1; q(); q();
    endtask

    task automatic m_wbit(input bit b);
        sda_m = b; q(); scl_m = 1'b1; q(); q(); scl_m = 1'b0; q();
    endtask

    task automatic m_rbit(output bit b);
        sda_m = 1'b1; q(); scl_m = 1'b1; q(); b = sda_line; q(); scl_m = 1'b0; q();
    endtask

    task automatic m_wbyte(input logic [7:0] v, output bit ack);
        bit nb;
        for (int i = 7; i >= 0; i--) m_wbit(v[i]);
        m_rbit(nb);
        ack = !nb;
    endtask

    task automatic m_rbyte(input bit mack, output logic [7:0] v);
        bit b;
        for (int i = 7; i >= 0; i--) begin
            m_rbit(b);
            v[i] = b;
        end
        m_wbit(!mack);
    endtask

    task automatic check_rd(input int a, input string tag);
        rd_addr = PW'(a);
        @(negedge clk);
        check_val(tag, rd_data, mmem[a]);
    endtask

    // START, device address (write), register, the bytes queued in wdat, STOP.
    task automatic tx_write(input logic [6:0] a, input int rg, input string tag);
        bit          ack, hit, ok;
        int          base, oe0;
        logic [15:0] expq [$];
        hit  = (a == DEV);
        ok   = hit && (rg < DEPTH);
        base = wr_q.size();
        oe0  = oe_cnt;
        m_start();
        m_wbyte({a, 1'b0}, ack);
        check_val({tag, "_addr_ack"}, ack, hit);
        m_wbyte(8'(rg), ack);
        check_val({tag, "_reg_ack"}, ack, ok);
        if (ok) mptr = rg;
        foreach (wdat[i]) begin
            m_wbyte(wdat[i], ack);
            check_val({tag, "_data_ack"}, ack, ok);
            if (ok) begin
                expq.push_back({8'(mptr), wdat[i]});
                mmem[mptr] = wdat[i];
                mptr = (mptr + 1) % DEPTH;
            end
        end
        m_stop();
        check_val({tag, "_wr_count"}, wr_q.size() - base, expq.size());
        foreach (expq[i])
            if (base + i < wr_q.size()) check_val({tag, "_wr_addr_data"}, wr_q[base + i], expq[i]);
        if (!hit) check_val({tag, "_no_drive"}, oe_cnt - oe0, 0);
        check_val({tag, "_busy_lo"}, busy, 0);
    endtask

    // Optional register-pointer write, then (repeated) START and an n-byte read.
    task automatic tx_read(input logic [6:0] a, input bit use_reg, input int rg, input int n,
                           input string tag);
        bit         ack, hit;
        logic [7:0] v;
        hit = (a == DEV);
        m_start();
        if (use_reg) begin
            m_wbyte({DEV, 1'b0}, ack);
            check_val({tag, "_waddr_ack"}, ack, 1);
            m_wbyte(8'(rg), ack);
            check_val({tag, "_reg_ack"}, ack, rg < DEPTH);
            if (rg < DEPTH) mptr = rg;
            m_start();
        end
        m_wbyte({a, 1'b1}, ack);
        check_val({tag, "_raddr_ack"}, ack, hit);
        for (int i = 0; i < n; i++) begin
            m_rbyte(i != n - 1, v);
            check_val({tag, "_data"}, v, hit ? mmem[mptr] : 8'hFF);
            if (hit && i != n - 1) mptr = (mptr + 1) % DEPTH;
        end
        check_val({tag, "_released"}, sda_oe, 0);
        check_val({tag, "_busy_hi"}, busy, 1);
        m_stop();
        check_val({tag, "_busy_lo"}, busy, 0);
    endtask

    task automatic run_all();
        bit         ack;
        int         base;
        logic [7:0] aw;

        model_reset();
        repeat (3) @(negedge clk);
        check_val("rst_sda_oe", sda_oe, 0);
        check_val("rst_busy", busy, 0);
        check_val("rst_wr_stb", wr_stb, 0);
        check_val("rst_wr_addr", wr_addr, 0);
        check_val("rst_wr_data", wr_data, 0);
        check_val("rst_rd_data", rd_data, 0);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        check_rd(37, "local_rd37");
        check_rd(0, "local_rd0");

        // Reset while the target is driving the address ACK.
        aw = {DEV, 1'b0};
        m_start();
        for (int i = 7; i >= 0; i--) m_wbit(aw[i]);
        check_val("ack_driven", sda_oe, 1);
        check_val("busy_mid", busy, 1);
        rst_n = 1'b0;
        #1;
        check_val("midrst_sda_oe", sda_oe, 0);
        check_val("midrst_busy", busy, 0);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        repeat (4) @(negedge clk);
        tx_read(DEV, 1'b1, 37, 1, "rd37");

        wdat.delete(); wdat.push_back(8'hA1); wdat.push_back(8'hB2);
        tx_write(DEV, 5, "wr_inc");
        check_rd(6, "local_rd6");
        tx_read(DEV, 1'b1, 5, 2, "comb_rd");

        wdat.delete(); wdat.push_back(8'h11); wdat.push_back(8'h22);
        tx_write(7'h50, 3, "miss");
        wdat.delete(); wdat.push_back(8'h33);
        tx_write(DEV, 8'h30, "oor");
        wdat.delete(); wdat.push_back(8'hC3); wdat.push_back(8'hD4);
        tx_write(DEV, 38, "wrap");
        check_rd(38, "local_rd38");
        check_rd(0, "local_rd0_wrap");

        // STOP after four data bits must leave storage and pointer alone.
        wdat.delete(); wdat.push_back(8'h3C);
        tx_write(DEV, 12, "pre_abort");
        base = wr_q.size();
        m_start();
        m_wbyte({DEV, 1'b0}, ack);
        check_val("abort_addr_ack", ack, 1);
        m_wbyte(8'd12, ack);
        check_val("abort_reg_ack", ack, 1);
        mptr = 12;
        for (int i = 0; i < 4; i++) m_wbit(1'($urandom_range(0, 1)));
        m_stop();
        check_val("abort_no_wr", wr_q.size() - base, 0);
        tx_read(DEV, 1'b0, 0, 1, "abort_ptr");

        // A short SCL pulse inside a data byte must not count as a bit.
        base = wr_q.size();
        m_start();
        m_wbyte({DEV, 1'b0}, ack);
        check_val("glitch_addr_ack", ack, 1);
        m_wbyte(8'd7, ack);
        check_val("glitch_reg_ack", ack, 1);
        mptr = 7;
        scl_m = 1'b1;
        repeat (FILT - 1) @(negedge clk);
        scl_m = 1'b0;
        q();
        m_wbyte(8'h5C, ack);
        check_val("glitch_data_ack", ack, 1);
        m_stop();
        mmem[7] = 8'h5C;
        mptr = 8;
        check_val("glitch_wr_count", wr_q.size() - base, 1);
        if (wr_q.size() > base) check_val("glitch_wr", wr_q[base], {8'd7, 8'h5C});

        for (int t = 0; t < 16; t++) begin
            logic [6:0] a;
            int         kind, n, rg;
            a = DEV;
            if ($urandom_range(0, 5) == 0) begin
                a = 7'($urandom_range(0, 127));
                if (a == DEV) a = 7'h2A;
            end
            kind = $urandom_range(0, 2);
            rg   = $urandom_range(0, DEPTH + 6);
            n    = $urandom_range(1, 3);
            case (kind)
                0: begin
                    wdat.delete();
                    for (int i = 0; i < n; i++) wdat.push_back(8'($urandom));
                    tx_write(a, rg, "rnd_wr");
                end
                1:       tx_read(a, 1'b1, rg, n, "rnd_rdreg");
                default: tx_read(a, 1'b0, 0, n, "rnd_rd");
            endcase
            check_rd($urandom_range(0, DEPTH - 1), "rnd_local");
        end
    endtask

    initial begin
        fork
            run_all();
            begin
                repeat (95000) @(posedge clk);
                check_val("watchdog_timeout", 1, 0);
            end
        join_any
        disable fork;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
